timekeeper: RTL and testbench

Parametrised time-of-day core for the seven-segment clock design. Replaces the separate divider/counter pair: integrates the 1 Hz prescaler and keeps hours, minutes and seconds, with runtime time setting, button-style field increments and a 12/24-hour display mode. An optional alarm comparator is compiled in by macro. Its outputs feed the LED/hex display controller directly.

---
 rtl/timekeeper_pkg.sv | 29 ++
 rtl/timekeeper_tick_prescaler.sv | 30 +++
 rtl/timekeeper.sv | 145 ++++++++++++++
 tb/tb_timekeeper.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timekeeper_pkg.sv
// rtl/timekeeper_pkg.sv - shared time-of-day types, field limits and display helpers
package timekeeper_pkg;

    typedef struct packed {
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
    } time_t;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] HOUR_MAX = 5'd23;

    function automatic logic [4:0] to_12h(input logic [4:0] hour);
        if (hour == 5'd0) begin
            return 5'd12;
        end else if (hour > 5'd12) begin
            return hour - 5'd12;
        end else begin
            return hour;
        end
    endfunction

    function automatic logic time_valid(input logic [4:0] hour, input logic [5:0] min,
                                        input logic [5:0] sec);
        return (hour <= HOUR_MAX) && (min <= MIN_MAX) && (sec <= SEC_MAX);
    endfunction

endpackage

// File: rtl/timekeeper_tick_prescaler.sv
// rtl/timekeeper_tick_prescaler.sv - divides clk down to a one-cycle tick every CLK_HZ enabled cycles
module tick_prescaler #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] count;

    assign tick = enable && (count == CNT_LAST);

    // clear wins over enable so a load restarts a full second even while frozen
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == CNT_LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/timekeeper.sv
// rtl/timekeeper.sv - hh:mm:ss core with set/increment and 12/24h display; alarm via TIMEKEEPER_ALARM_EN
module timekeeper
    import timekeeper_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       mode12,
    input  logic       set_valid,
    input  logic [4:0] set_hour,
    input  logic [5:0] set_min,
    input  logic [5:0] set_sec,
    input  logic       inc_min,
    input  logic       inc_hour,
`ifdef TIMEKEEPER_ALARM_EN
    input  logic       alarm_set_valid,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic       alarm_arm,
    input  logic       alarm_ack,
    output logic       alarm,
`endif
    output logic       set_err,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic       pm,
    output logic       sec_pulse,
    output logic       day_pulse
);

    time_t tm;
    time_t tm_next;
    logic  tick;
    logic  load_ok;
    logic  load_bad;
    logic  alarm_bad;
    logic  tick_taken;
    logic  wrap_day;

    tick_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clear  (load_ok),
        .tick   (tick)
    );

    // loads beat increments beat ticks; a tick losing arbitration is simply dropped
    always_comb begin
        tm_next    = tm;
        load_ok    = 1'b0;
        load_bad   = 1'b0;
        tick_taken = 1'b0;
        wrap_day   = 1'b0;
        if (set_valid) begin
            if (time_valid(set_hour, set_min, set_sec)) begin
                load_ok      = 1'b1;
                tm_next.hour = set_hour;
                tm_next.min  = set_min;
                tm_next.sec  = set_sec;
            end else begin
                load_bad = 1'b1;
            end
        end else if (inc_hour || inc_min) begin
            if (inc_hour) tm_next.hour = (tm.hour == HOUR_MAX) ? 5'd0 : tm.hour + 5'd1;
            if (inc_min)  tm_next.min  = (tm.min == MIN_MAX) ? 6'd0 : tm.min + 6'd1;
        end else if (tick) begin
            tick_taken = 1'b1;
            if (tm.sec != SEC_MAX) begin
                tm_next.sec = tm.sec + 6'd1;
            end else begin
                tm_next.sec = 6'd0;
                if (tm.min != MIN_MAX) begin
                    tm_next.min = tm.min + 6'd1;
                end else begin
                    tm_next.min = 6'd0;
                    if (tm.hour != HOUR_MAX) begin
                        tm_next.hour = tm.hour + 5'd1;
                    end else begin
                        tm_next.hour = 5'd0;
                        wrap_day     = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tm        <= '0;
            hour      <= mode12 ? to_12h(5'd0) : 5'd0;
            pm        <= 1'b0;
            sec_pulse <= 1'b0;
            day_pulse <= 1'b0;
            set_err   <= 1'b0;
        end else begin
            tm        <= tm_next;
            hour      <= mode12 ? to_12h(tm_next.hour) : tm_next.hour;
            pm        <= (tm_next.hour >= 5'd12);
            sec_pulse <= tick_taken;
            day_pulse <= wrap_day;
            set_err   <= load_bad || alarm_bad;
        end
    end

    assign sec = tm.sec;
    assign min = tm.min;

`ifdef TIMEKEEPER_ALARM_EN
    logic [4:0] alarm_hour_q;
    logic [5:0] alarm_min_q;
    logic       alarm_match;

    assign alarm_bad   = alarm_set_valid && !time_valid(alarm_hour, alarm_min, 6'd0);
    assign alarm_match = tick_taken && (tm_next.sec == 6'd0) &&
                         (tm_next.hour == alarm_hour_q) && (tm_next.min == alarm_min_q);

    // a fresh match outranks ack so a same-cycle ack cannot swallow it
    always_ff @(posedge clk) begin
        if (!reset) begin
            alarm_hour_q <= 5'd0;
            alarm_min_q  <= 6'd0;
            alarm        <= 1'b0;
        end else begin
            if (alarm_set_valid && !alarm_bad) begin
                alarm_hour_q <= alarm_hour;
                alarm_min_q  <= alarm_min;
            end
            if (!alarm_arm) begin
                alarm <= 1'b0;
            end else if (alarm_match) begin
                alarm <= 1'b1;
            end else if (alarm_ack) begin
                alarm <= 1'b0;
            end
        end
    end
`else
    assign alarm_bad = 1'b0;
`endif

endmodule

// File: tb/tb_timekeeper.sv
// tb/tb_timekeeper.sv - vector table, corner sequences and seconds-of-day model for timekeeper
`timescale 1ns/1ps
module tb_timekeeper;

    localparam int CLK_HZ = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       mode12 = 1'b0;
    logic       set_valid = 1'b0;
    logic [4:0] set_hour = '0;
    logic [5:0] set_min = '0;
    logic [5:0] set_sec = '0;
    logic       inc_min = 1'b0;
    logic       inc_hour = 1'b0;
    logic       set_err;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       pm;
    logic       sec_pulse;
    logic       day_pulse;
`ifdef TIMEKEEPER_ALARM_EN
    logic       alarm_set_valid = 1'b0;
    logic [4:0] alarm_hour = '0;
    logic [5:0] alarm_min = '0;
    logic       alarm_arm = 1'b0;
    logic       alarm_ack = 1'b0;
    logic       alarm;
`endif

    timekeeper #(.CLK_HZ(CLK_HZ)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .mode12          (mode12),
        .set_valid       (set_valid),
        .set_hour        (set_hour),
        .set_min         (set_min),
        .set_sec         (set_sec),
        .inc_min         (inc_min),
        .inc_hour        (inc_hour),
`ifdef TIMEKEEPER_ALARM_EN
        .alarm_set_valid (alarm_set_valid),
        .alarm_hour      (alarm_hour),
        .alarm_min       (alarm_min),
        .alarm_arm       (alarm_arm),
        .alarm_ack       (alarm_ack),
        .alarm           (alarm),
`endif
        .set_err         (set_err),
        .sec             (sec),
        .min             (min),
        .hour            (hour),
        .pm              (pm),
        .sec_pulse       (sec_pulse),
        .day_pulse       (day_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // reference state: seconds since midnight plus enabled cycles into the current second
    int m_tod = 0;
    int m_phase = 0;
    bit m_m12 = 0;
    bit m_sp = 0;
    bit m_dp = 0;
    bit m_err = 0;
    bit m_alarm = 0;
    int m_al_h = 0;
    int m_al_m = 0;

    typedef struct {
        bit sv; int sh; int sm; int ss; bit im; bit ih; bit m12;
        int eh; int em; int es; bit epm; bit eerr;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int disp_hour(input int h, input bit m12);
        if (!m12) return h;
        return (h % 12 == 0) ? 12 : h % 12;
    endfunction

    task automatic model_edge();
        bit tick;
        bit taken;
        int h;
        int m;
        int s;
        m_m12 = mode12;
        if (!reset) begin
            m_tod = 0; m_phase = 0; m_sp = 0; m_dp = 0; m_err = 0;
            m_alarm = 0; m_al_h = 0; m_al_m = 0;
            return;
        end
        tick  = enable && (m_phase == CLK_HZ - 1);
        taken = 0;
        if (enable) m_phase = (m_phase + 1) % CLK_HZ;
        m_sp = 0; m_dp = 0; m_err = 0;
        if (set_valid) begin
            if (set_hour < 24 && set_min < 60 && set_sec < 60) begin
                m_tod   = set_hour * 3600 + set_min * 60 + set_sec;
                m_phase = 0;
            end else begin
                m_err = 1;
            end
        end else if (inc_min || inc_hour) begin
            h = m_tod / 3600; m = (m_tod / 60) % 60; s = m_tod % 60;
            if (inc_hour) h = (h + 1) % 24;
            if (inc_min)  m = (m + 1) % 60;
            m_tod = h * 3600 + m * 60 + s;
        end else if (tick) begin
            m_tod = (m_tod + 1) % 86400;
            m_sp  = 1;
            m_dp  = (m_tod == 0);
            taken = 1;
        end
`ifdef TIMEKEEPER_ALARM_EN
        if (!alarm_arm) m_alarm = 0;
        else if (taken && m_tod % 60 == 0 && m_tod / 3600 == m_al_h && (m_tod / 60) % 60 == m_al_m)
            m_alarm = 1;
        else if (alarm_ack) m_alarm = 0;
        if (alarm_set_valid) begin
            if (alarm_hour < 24 && alarm_min < 60) begin
                m_al_h = alarm_hour; m_al_m = alarm_min;
            end else begin
                m_err = 1;
            end
        end
`endif
    endtask

    task automatic check_model();
        logic [31:0] act;
        logic [31:0] exp;
        int h;
        h   = m_tod / 3600;
        act = {11'd0, hour, min, sec, pm, sec_pulse, day_pulse, set_err};
        exp = {11'd0, 5'(disp_hour(h, m_m12)), 6'((m_tod / 60) % 60), 6'(m_tod % 60),
               (h >= 12), m_sp, m_dp, m_err};
`ifdef TIMEKEEPER_ALARM_EN
        act[31] = alarm;
        exp[31] = m_alarm;
`endif
        chk("model", act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic load(input int h, input int m, input int s);
        set_valid = 1; set_hour = 5'(h); set_min = 6'(m); set_sec = 6'(s);
        step();
        set_valid = 0;
    endtask

    initial begin
        vecs.push_back('{1, 23, 59, 58, 0, 0, 0, 23, 59, 58, 1, 0});
        vecs.push_back('{1, 24,  0,  0, 0, 0, 0, 23, 59, 58, 1, 1});
        vecs.push_back('{0,  0,  0,  0, 0, 0, 0, 23, 59, 58, 1, 0});
        vecs.push_back('{1, 12, 60,  0, 0, 0, 0, 23, 59, 58, 1, 1});
        vecs.push_back('{1,  0,  0,  0, 0, 0, 1, 12,  0,  0, 0, 0});
        vecs.push_back('{1, 13,  5,  7, 0, 0, 1,  1,  5,  7, 1, 0});
        vecs.push_back('{0,  0,  0,  0, 0, 0, 0, 13,  5,  7, 1, 0});
        vecs.push_back('{1, 12,  0,  0, 0, 0, 1, 12,  0,  0, 1, 0});
        vecs.push_back('{1, 10, 59, 30, 0, 0, 0, 10, 59, 30, 0, 0});
        vecs.push_back('{0,  0,  0,  0, 1, 0, 0, 10,  0, 30, 0, 0});
        vecs.push_back('{0,  0,  0,  0, 0, 1, 0, 11,  0, 30, 0, 0});
        vecs.push_back('{1, 23, 10,  0, 0, 0, 0, 23, 10,  0, 1, 0});
        vecs.push_back('{0,  0,  0,  0, 1, 1, 1, 12, 11,  0, 0, 0});
        vecs.push_back('{1,  0,  0, 60, 0, 0, 1, 12, 11,  0, 0, 1});

        // reset state
        step();
        step();
        chk("reset_sec", sec, 0);
        chk("reset_min", min, 0);
        chk("reset_hour", hour, 0);
        chk("reset_pm", pm, 0);
        chk("reset_pulses", {sec_pulse, day_pulse, set_err}, 0);
        mode12 = 1;
        step();
        chk("reset_hour12", hour, 12);
        mode12 = 0;
        step();

        // first seconds after release
        reset = 1;
        enable = 1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("first_pulse", sec_pulse, (i % 4 == 3));
            if (i == 3) chk("first_sec1", sec, 1);
            if (i == 7) chk("first_sec2", sec, 2);
            chk("first_min_hour", {min, hour}, 0);
        end

        // single-cycle vectors with the clock frozen
        enable = 0;
        foreach (vecs[i]) begin
            set_valid = vecs[i].sv; set_hour = 5'(vecs[i].sh); set_min = 6'(vecs[i].sm);
            set_sec = 6'(vecs[i].ss); inc_min = vecs[i].im; inc_hour = vecs[i].ih;
            mode12 = vecs[i].m12;
            step();
            set_valid = 0; inc_min = 0; inc_hour = 0;
            chk("vec_hour", hour, vecs[i].eh);
            chk("vec_min", min, vecs[i].em);
            chk("vec_sec", sec, vecs[i].es);
            chk("vec_pm", pm, vecs[i].epm);
            chk("vec_err", set_err, vecs[i].eerr);
        end

        // day rollover
        mode12 = 0;
        enable = 1;
        load(23, 59, 58);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("roll_pulse_a", sec_pulse, (i == 4));
        end
        chk("roll_sec59", sec, 59);
        chk("roll_no_day", day_pulse, 0);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("roll_day", day_pulse, (i == 4));
        end
        chk("roll_zero", {hour, min, sec}, 0);
        chk("roll_pulse_b", sec_pulse, 1);

        // inc_min colliding with a tick
        load(5, 59, 58);
        for (int i = 0; i < 4; i++) step();
        chk("collide_pre_sec", sec, 59);
        for (int i = 0; i < 3; i++) step();
        inc_min = 1;
        step();
        inc_min = 0;
        chk("collide_min", min, 0);
        chk("collide_hour", hour, 5);
        chk("collide_sec", sec, 59);
        chk("collide_no_pulse", sec_pulse, 0);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("collide_next_pulse", sec_pulse, (i == 4));
        end
        chk("collide_carry", {min, sec}, {6'd1, 6'd0});

        // enable freeze keeps the partial second
        load(1, 2, 3);
        step();
        step();
        enable = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("freeze_pulse", sec_pulse, 0);
        end
        enable = 1;
        step();
        chk("resume_pulse_a", sec_pulse, 0);
        step();
        chk("resume_pulse_b", sec_pulse, 1);
        chk("resume_sec", sec, 4);

`ifdef TIMEKEEPER_ALARM_EN
        alarm_arm = 1;
        alarm_set_valid = 1; alarm_hour = 5'd24; alarm_min = 6'd0;
        step();
        chk("alarm_reject_err", set_err, 1);
        alarm_hour = 5'd7; alarm_min = 6'd30;
        step();
        alarm_set_valid = 0;
        chk("alarm_accept_err", set_err, 0);
        load(7, 29, 59);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("alarm_fire", alarm, (i == 4));
        end
        chk("alarm_time", {hour, min, sec}, {5'd7, 6'd30, 6'd0});
        for (int i = 0; i < 6; i++) begin
            step();
            chk("alarm_sticky", alarm, 1);
        end
        alarm_ack = 1;
        step();
        alarm_ack = 0;
        chk("alarm_ack", alarm, 0);
        load(7, 29, 59);
        for (int i = 0; i < 4; i++) step();
        chk("alarm_refire", alarm, 1);
        alarm_arm = 0;
        step();
        chk("alarm_disarm", alarm, 0);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            enable    = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 49) == 0) mode12 = ~mode12;
            set_valid = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) begin
                set_hour = 5'd23; set_min = 6'd59; set_sec = 6'($urandom_range(55, 60));
            end else begin
                set_hour = 5'($urandom_range(0, 31));
                set_min  = 6'($urandom_range(0, 63));
                set_sec  = 6'($urandom_range(0, 63));
            end
            inc_min  = ($urandom_range(0, 29) == 0);
            inc_hour = ($urandom_range(0, 29) == 0);
`ifdef TIMEKEEPER_ALARM_EN
            alarm_set_valid = ($urandom_range(0, 59) == 0);
            alarm_hour = 5'($urandom_range(0, 25));
            alarm_min  = 6'($urandom_range(0, 61));
            alarm_arm  = ($urandom_range(0, 19) != 0);
            alarm_ack  = ($urandom_range(0, 9) == 0);
`endif
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
